// File: rtl/weight_serializer.sv
// Streams the set-bit locations of one captured word as one beat per transfer,
// with first/last/empty framing and a count of fully emitted words.
module weight_serializer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       PC,
   input  logic [2:0]       L0,
   input  logic [2:0]       L1,
   input  logic [2:0]       L2,
   input  logic [2:0]       L3,
   input  logic [2:0]       L4,
   input  logic [2:0]       L5,
   input  logic [2:0]       L6,
   input  logic [2:0]       L7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_loc,
   output logic [2:0]       out_idx,
   output logic             out_first,
   output logic             out_last,
   output logic             out_empty,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t     state, state_nx;
   logic [3:0] pc_r;
   logic [2:0] loc_buf [8];
   logic [2:0] idx;
   logic       accept;
   logic       xfer;
   logic       last_beat;

   // An empty word still produces a single marker beat, so it is always last.
   assign last_beat = (pc_r == 4'd0) || ({1'b0, idx} == (pc_r - 4'd1));
   assign xfer      = (state == EMIT) && out_ready;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = EMIT;
         EMIT: if (xfer && last_beat && !accept) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_loc   = '0;
      out_idx   = '0;
      out_first = 1'b0;
      out_last  = 1'b0;
      out_empty = 1'b0;
      in_ready  = (state == IDLE);
      if (state == EMIT) begin
         out_valid = 1'b1;
         out_loc   = (pc_r == 4'd0) ? 3'd0 : loc_buf[idx];
         out_idx   = idx;
         out_first = (idx == 3'd0);
         out_last  = last_beat;
         out_empty = (pc_r == 4'd0);
         // Freeing the buffer on the final transfer lets the next word load without a bubble.
         in_ready  = out_ready && last_beat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r     <= '0;
         idx      <= '0;
         word_cnt <= '0;
         for (int unsigned i = 0; i < 8; i++) loc_buf[i] <= '0;
      end else begin
         if (xfer && last_beat) word_cnt <= word_cnt + 1'b1;
         if (accept) begin
            pc_r       <= (PC > 4'd8) ? 4'd8 : PC;
            idx        <= '0;
            loc_buf[0] <= L0;
            loc_buf[1] <= L1;
            loc_buf[2] <= L2;
            loc_buf[3] <= L3;
            loc_buf[4] <= L4;
            loc_buf[5] <= L5;
            loc_buf[6] <= L6;
            loc_buf[7] <= L7;
         end else if (xfer && !last_beat) begin
            idx <= idx + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_weight_serializer.sv
// Directed bench for weight_serializer; counter width reduced to 4 bits so wrap is reachable.
module tb_weight_serializer;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    PC;
   logic [2:0]    L0, L1, L2, L3, L4, L5, L6, L7;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    out_loc;
   logic [2:0]    out_idx;
   logic          out_first;
   logic          out_last;
   logic          out_empty;
   logic [CW-1:0] word_cnt;

   int total  = 0;
   int passed = 0;

   weight_serializer #(.CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .PC        (PC),
      .L0        (L0),
      .L1        (L1),
      .L2        (L2),
      .L3        (L3),
      .L4        (L4),
      .L5        (L5),
      .L6        (L6),
      .L7        (L7),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_loc   (out_loc),
      .out_idx   (out_idx),
      .out_first (out_first),
      .out_last  (out_last),
      .out_empty (out_empty),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packed beat: {valid, loc, idx, first, last, empty}
   task automatic beat(input string tag, input logic [2:0] loc, input logic [2:0] idx,
                       input logic f, input logic l, input logic e);
      chk(tag, {out_valid, out_loc, out_idx, out_first, out_last, out_empty},
          {1'b1, loc, idx, f, l, e});
   endtask

   // locs = {L7,L6,L5,L4,L3,L2,L1,L0}
   task automatic load(input logic [3:0] pc, input logic [23:0] locs);
      PC = pc;
      L0 = locs[2:0];   L1 = locs[5:3];   L2 = locs[8:6];   L3 = locs[11:9];
      L4 = locs[14:12]; L5 = locs[17:15]; L6 = locs[20:18]; L7 = locs[23:21];
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int cyc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      load(4'd0, 24'd0);
      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_outs", {out_loc, out_idx, out_first, out_last, out_empty}, 0);
      chk("rst_cnt", word_cnt, 0);
      @(negedge clk); rst = 1'b0;
      #1 chk("rel_in_ready", in_ready, 1);

      // Normal word 8'b1010_0100
      load(4'd3, {15'd0, 3'd7, 3'd5, 3'd2}); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      #1 beat("norm_b0", 3'd2, 3'd0, 1, 0, 0);
      chk("norm_inrdy_mid", in_ready, 0);
      @(negedge clk); #1 beat("norm_b1", 3'd5, 3'd1, 0, 0, 0);
      @(negedge clk); #1 beat("norm_b2", 3'd7, 3'd2, 0, 1, 0);
      chk("norm_inrdy_last", in_ready, 1);
      chk("norm_cnt_before", word_cnt, 0);
      @(negedge clk); #1 chk("norm_idle", out_valid, 0);
      chk("norm_cnt", word_cnt, 1);

      // Empty word; L0 nonzero must not leak onto out_loc
      load(4'd0, {21'd0, 3'd5}); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      #1 beat("empty_b", 3'd0, 3'd0, 1, 1, 1);
      @(negedge clk); #1 chk("empty_idle", out_valid, 0);
      chk("empty_inrdy", in_ready, 1);
      chk("empty_cnt", word_cnt, 2);

      // Backpressure on 8'hFF, out_ready pattern 1,0,0,1
      load(4'd8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      k = 0; cyc = 0;
      while (k < 8 && cyc < 40) begin
         out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         #1 beat("bp_beat", 3'(k), 3'(k), k == 0, k == 7, 0);
         chk("bp_inrdy", in_ready, (out_ready && k == 7) ? 1 : 0);
         if (out_ready) k++;
         cyc++;
         @(negedge clk);
      end
      chk("bp_transfers", k, 8);
      chk("bp_cycles", cyc, 16);
      out_ready = 1'b1;
      #1 chk("bp_idle", out_valid, 0);
      chk("bp_cnt", word_cnt, 3);

      // Back-to-back: A=8'h81 then B=8'h10 held valid
      load(4'd2, {18'd0, 3'd7, 3'd0}); in_valid = 1'b1;
      @(negedge clk); load(4'd1, {21'd0, 3'd4});
      #1 beat("b2b_a0", 3'd0, 3'd0, 1, 0, 0);
      chk("b2b_inrdy_a0", in_ready, 0);
      @(negedge clk); #1 beat("b2b_a1", 3'd7, 3'd1, 0, 1, 0);
      chk("b2b_inrdy_a1", in_ready, 1);
      @(negedge clk); in_valid = 1'b0;
      #1 beat("b2b_b0", 3'd4, 3'd0, 1, 1, 0);
      chk("b2b_cnt_mid", word_cnt, 4);
      @(negedge clk); #1 chk("b2b_idle", out_valid, 0);
      chk("b2b_cnt", word_cnt, 5);

      // PC=12 clamps to 8 beats
      load(4'd12, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1 beat("clamp_beat", 3'(i), 3'(i), i == 0, i == 7, 0);
         @(negedge clk);
      end
      #1 chk("clamp_idle", out_valid, 0);
      chk("clamp_cnt", word_cnt, 6);

      // Reset mid-word after three transfers
      load(4'd8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 beat("rmw_beat", 3'(i), 3'(i), i == 0, 0, 0);
         @(negedge clk);
      end
      #1 beat("rmw_b3", 3'd3, 3'd3, 0, 0, 0);
      rst = 1'b1;
      #1 chk("rmw_valid", out_valid, 0);
      chk("rmw_cnt", word_cnt, 0);
      @(negedge clk); rst = 1'b0;
      #1 chk("rmw_inrdy", in_ready, 1);
      chk("rmw_idle", out_valid, 0);
      load(4'd2, {18'd0, 3'd6, 3'd3}); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      #1 beat("rmw_n0", 3'd3, 3'd0, 1, 0, 0);
      @(negedge clk); #1 beat("rmw_n1", 3'd6, 3'd1, 0, 1, 0);
      @(negedge clk); #1 chk("rmw_n_idle", out_valid, 0);
      chk("rmw_n_cnt", word_cnt, 1);

      // 17 back-to-back empty words on a 4-bit counter
      rst = 1'b1; #1 rst = 1'b0;
      chk("wrap_cnt0", word_cnt, 0);
      load(4'd0, 24'd0); in_valid = 1'b1;
      for (int w = 1; w <= 17; w++) begin
         @(negedge clk);
         if (w == 17) in_valid = 1'b0;
         #1 beat("wrap_beat", 3'd0, 3'd0, 1, 1, 1);
         chk("wrap_cnt", word_cnt, 32'((w - 1) % 16));
      end
      @(negedge clk); #1 chk("wrap_idle", out_valid, 0);
      chk("wrap_final", word_cnt, 1);
      chk("wrap_inrdy", in_ready, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/weight_serializer.md
Name: weight_serializer

Overview:
- Downstream of weight_locator; consumes popcount PC and set-bit locations L0..L7 of one 8-bit word R.
- Captures them on a valid/ready handshake, then streams each set-bit location one per beat on a valid/ready output.
- Gives downstream datapaths a sparse, in-order index stream; counts completed words.

Parameters:
- CNT_W, 16, width of the completed-word counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  PC/L0..L7 valid this cycle
- in_ready  out  1  block accepts a new word
- PC  in  4  number of set bits in R (legal 0..8)
- L0..L7  in  3 each  set-bit positions, ascending (L0 = lowest set bit); Lk meaningful only for k < PC
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_loc  out  3  current set-bit location
- out_idx  out  3  beat index within word (0..PC-1)
- out_first  out  1  first beat of word
- out_last  out  1  last beat of word
- out_empty  out  1  word had PC=0 (single marker beat)
- word_cnt  out  CNT_W  words fully emitted

Behaviour:
- Reset (async, immediate): state IDLE; out_valid=0, out_loc=0, out_idx=0, out_first=0, out_last=0, out_empty=0, word_cnt=0; captured PC/L registers cleared. in_ready=1 once reset is released.
- States: IDLE, EMIT.
- Input accept = in_valid && in_ready. On accept:
  - Latch pc_r = min(PC, 8). PC 9..15 clamps to 8.
  - Latch L0..L7 into loc_buf[0..7]; idx=0; go to EMIT.
- EMIT outputs, all registered state, no input->output combinational path except in_ready:
  - out_valid=1; out_loc=loc_buf[idx]; out_idx=idx; out_first=(idx==0).
  - out_last=(pc_r==0) || (idx==pc_r-1); out_empty=(pc_r==0).
  - If pc_r==0: exactly one beat, with out_loc=0, out_empty=1, out_first=1, out_last=1.
- Beat transfer = out_valid && out_ready.
  - Non-last beat: idx++.
  - Last beat: word_cnt++ (wrapping), then:
    - if a new word is accepted the same cycle, reload and stay in EMIT;
    - else go to IDLE.
- Backpressure: while out_ready=0, out_loc/out_idx/flags are held stable and idx does not advance.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This combinational out_ready->in_ready path is intentional and gives back-to-back words with no bubble.
- Latency: first beat appears the cycle after accept. A word with PC=n≥1 occupies n beats; PC=0 occupies 1 beat.
- Inputs are ignored when in_ready=0; captured data is never overwritten mid-word.
- Reset asserted mid-word aborts the word: no further beats, and word_cnt is not incremented for it.

Test Plan:
- Normal word: R=8'b1010_0100 → PC=3, L0=2, L1=5, L2=7, out_ready=1. Expect beats out_loc 2,5,7 with out_idx 0,1,2, out_first only on 2 and out_last only on 7; first beat one cycle after accept; word_cnt 0→1.
- Empty word: PC=0. Expect exactly one beat with out_empty=1, out_first=1, out_last=1, out_loc=0; word_cnt+1; back to IDLE (in_ready=1).
- Backpressure: R=8'hFF (PC=8, L=0..7) with out_ready toggling 1,0,0,1,… Expect locs 0..7 each exactly once, in order, stable while stalled; 8 transfers total; in_ready=0 until the last transfer.
- Back-to-back: word A (R=8'h81, locs 0,7) with word B (R=8'h10, loc 4) held valid. Expect B accepted in the same cycle as A's last beat; stream 0,7,4 with no idle cycle; word_cnt=2.
- Clamp/wrap: PC=12 with L0..L7=0..7 → exactly 8 beats. With CNT_W=4, 17 PC=0 words → word_cnt=1.
- Reset mid-word: R=8'hFF; assert rst after beat 3 transfers. Expect out_valid=0 immediately (asynchronous), word_cnt=0, in_ready=1 after release, and a following word streamed correctly from idx 0.
